// File: rtl/ece453_bus_defs.sv
// Shared definitions for the ARM chip-select-5 bus front end: state codes,
// default bus widths and a saturating counter helper.
package ece453_bus_defs;

    localparam int DEF_ADDR_W = 24;
    localparam int DEF_DATA_W = 32;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_SETTLE_W  = 3'd1;
    localparam logic [2:0] ST_SETTLE_R  = 3'd2;
    localparam logic [2:0] ST_CAPTURE_W = 3'd3;
    localparam logic [2:0] ST_CAPTURE_R = 3'd4;
    localparam logic [2:0] ST_WAIT_REL  = 3'd5;

    typedef enum logic [2:0] {
        IDLE      = ST_IDLE,
        SETTLE_W  = ST_SETTLE_W,
        SETTLE_R  = ST_SETTLE_R,
        CAPTURE_W = ST_CAPTURE_W,
        CAPTURE_R = ST_CAPTURE_R,
        WAIT_REL  = ST_WAIT_REL
    } bus_state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for a single asynchronous control line; both flops
// take RST_VAL in reset so the synchronised line starts inactive.
module sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/arm_bus_sync.sv
// Turns asynchronous ARM CS5 bus strobes into single-cycle write/read pulses
// in the FPGA_CLK1 domain, with captured address/data/lanes and an error count.
module arm_bus_sync
    import ece453_bus_defs::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int SETTLE = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              as,
    input  logic              ws_n,
    input  logic              rs_n,
    input  logic [3:0]        be,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data_in,
    output logic              wr_stb,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [3:0]        wr_be,
    output logic              rd_stb,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              busy,
    output logic [7:0]        err_cnt
);

    localparam logic [2:0] SETTLE_LAST = 3'(SETTLE - 1);

    logic as_s;
    logic ws_n_s;
    logic rs_n_s;
    logic wreq;
    logic rreq;

    bus_state_t state;
    bus_state_t state_nxt;
    logic [2:0] settle_cnt;
    logic [2:0] settle_cnt_nxt;
    logic       cap_w;
    logic       cap_r;
    logic       err_inc;

    sync2 #(.RST_VAL(1'b0)) u_sync_as (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (as),
        .q     (as_s)
    );

    sync2 #(.RST_VAL(1'b1)) u_sync_ws (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (ws_n),
        .q     (ws_n_s)
    );

    sync2 #(.RST_VAL(1'b1)) u_sync_rs (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rs_n),
        .q     (rs_n_s)
    );

    // Only synchronised strobes may steer the FSM; raw address/data are
    // looked at solely in the capture states where the bus holds them stable.
    assign wreq = as_s & ~ws_n_s;
    assign rreq = as_s & ~rs_n_s;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            settle_cnt <= 3'd0;
        end else begin
            state      <= state_nxt;
            settle_cnt <= settle_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        settle_cnt_nxt = settle_cnt;
        cap_w          = 1'b0;
        cap_r          = 1'b0;
        err_inc        = 1'b0;
        case (state)
            IDLE: begin
                settle_cnt_nxt = 3'd0;
                if (wreq && rreq) begin
                    err_inc   = 1'b1;
                    state_nxt = WAIT_REL;
                end else if (wreq) begin
                    state_nxt = SETTLE_W;
                end else if (rreq) begin
                    state_nxt = SETTLE_R;
                end
            end
            SETTLE_W: begin
                if (wreq && rreq) begin
                    err_inc   = 1'b1;
                    state_nxt = WAIT_REL;
                end else if (!wreq) begin
                    state_nxt = IDLE;
                end else if (settle_cnt == SETTLE_LAST) begin
                    state_nxt = CAPTURE_W;
                end else begin
                    settle_cnt_nxt = settle_cnt + 3'd1;
                end
            end
            SETTLE_R: begin
                if (wreq && rreq) begin
                    err_inc   = 1'b1;
                    state_nxt = WAIT_REL;
                end else if (!rreq) begin
                    state_nxt = IDLE;
                end else if (settle_cnt == SETTLE_LAST) begin
                    state_nxt = CAPTURE_R;
                end else begin
                    settle_cnt_nxt = settle_cnt + 3'd1;
                end
            end
            CAPTURE_W: begin
                cap_w     = 1'b1;
                state_nxt = WAIT_REL;
            end
            CAPTURE_R: begin
                cap_r     = 1'b1;
                state_nxt = WAIT_REL;
            end
            WAIT_REL: begin
                if (!wreq && !rreq) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Capture happens on the edge that leaves a CAPTURE state, so the pulse
    // and its captured payload appear together in the following cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_stb  <= 1'b0;
            rd_stb  <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            wr_be   <= 4'h0;
            rd_addr <= '0;
            err_cnt <= 8'h00;
        end else begin
            wr_stb <= 1'b0;
            rd_stb <= 1'b0;
            if (cap_w) begin
                wr_addr <= address;
                wr_data <= data_in;
                wr_be   <= ~be;
                wr_stb  <= (be != 4'hF);
            end
            if (cap_r) begin
                rd_addr <= address;
                rd_stb  <= 1'b1;
            end
            if (err_inc) begin
                err_cnt <= sat_inc8(err_cnt);
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_arm_bus_sync.sv
// Directed bench for arm_bus_sync: a transaction-level model predicts pulses,
// captured values and the error count; one monitor compares every cycle.
module tb_arm_bus_sync;

    localparam int ADDR_W = 24;
    localparam int DATA_W = 32;
    localparam int SETTLE = 2;
    localparam int WQ_W   = 16 + 4 + ADDR_W + DATA_W;
    localparam int RQ_W   = 16 + ADDR_W;
    localparam int LAT_MIN = 2 + SETTLE + 1 - 1;
    localparam int LAT_MAX = 2 + SETTLE + 1 + 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              as = 1'b0;
    logic              ws_n = 1'b1;
    logic              rs_n = 1'b1;
    logic [3:0]        be = 4'hF;
    logic [ADDR_W-1:0] address = '0;
    logic [DATA_W-1:0] data_in = '0;
    logic              wr_stb;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [3:0]        wr_be;
    logic              rd_stb;
    logic [ADDR_W-1:0] rd_addr;
    logic              busy;
    logic [7:0]        err_cnt;

    arm_bus_sync #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SETTLE(SETTLE)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .as      (as),
        .ws_n    (ws_n),
        .rs_n    (rs_n),
        .be      (be),
        .address (address),
        .data_in (data_in),
        .wr_stb  (wr_stb),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .wr_be   (wr_be),
        .rd_stb  (rd_stb),
        .rd_addr (rd_addr),
        .busy    (busy),
        .err_cnt (err_cnt)
    );

    // clock / reset
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;
    int n_wr  = 0;
    int n_rd  = 0;
    bit quiet = 1'b0;

    // model state: expected pulses plus what the capture registers must hold
    logic [WQ_W-1:0]   exp_wr_q[$];
    logic [RQ_W-1:0]   exp_rd_q[$];
    logic [ADDR_W-1:0] m_wr_addr = '0;
    logic [DATA_W-1:0] m_wr_data = '0;
    logic [3:0]        m_wr_be   = 4'h0;
    logic [ADDR_W-1:0] m_rd_addr = '0;
    int                m_err     = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_reset();
        exp_wr_q.delete();
        exp_rd_q.delete();
        m_wr_addr = '0;
        m_wr_data = '0;
        m_wr_be   = 4'h0;
        m_rd_addr = '0;
        m_err     = 0;
    endtask

    // A strobe long enough to survive sync + settle yields a capture; a write
    // with no lanes still captures but issues no pulse; two requests are an error.
    task automatic model_access(input bit w, input bit r, input logic [ADDR_W-1:0] a,
                                input logic [DATA_W-1:0] d, input logic [3:0] b,
                                input int len, input int start);
        if (w && r) begin
            m_err = (m_err < 255) ? m_err + 1 : 255;
        end else if (len >= SETTLE + 3) begin
            if (w) begin
                m_wr_addr = a;
                m_wr_data = d;
                m_wr_be   = ~b;
                if (b != 4'hF) exp_wr_q.push_back({16'(start), ~b, a, d});
            end else if (r) begin
                m_rd_addr = a;
                exp_rd_q.push_back({16'(start), a});
            end
        end
    endtask

    // driver: call at a negedge; returns at the negedge where strobes release
    task automatic access(input bit w, input bit r, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d, input logic [3:0] b, input int len);
        address = a;
        data_in = d;
        be      = b;
        as      = 1'b1;
        ws_n    = ~w;
        rs_n    = ~r;
        model_access(w, r, a, d, b, len, cyc);
        wait_neg(len);
        as   = 1'b0;
        ws_n = 1'b1;
        rs_n = 1'b1;
    endtask

    task automatic settle_quiet(input int gap);
        wait_neg(4);
        quiet = 1'b1;
        wait_neg(gap);
        quiet = 1'b0;
    endtask

    // scoreboard / monitor, sampled 2 ns after each active edge
    always @(posedge clk) begin : monitor
        logic [WQ_W-1:0] we;
        logic [RQ_W-1:0] re;
        int lat;
        #2;
        if (rst_n) begin
            if (wr_stb) begin
                n_wr++;
                check("wr_pulse_expected", 64'(exp_wr_q.size() != 0), 64'd1);
                check("wr_rd_overlap", 64'(rd_stb), 64'd0);
                if (exp_wr_q.size() != 0) begin
                    we  = exp_wr_q.pop_front();
                    lat = cyc - int'(we[WQ_W-1 -: 16]);
                    check("wr_latency_in_window", 64'(lat >= LAT_MIN && lat <= LAT_MAX), 64'd1);
                    check("wr_addr_at_pulse", 64'(wr_addr), 64'(we[DATA_W +: ADDR_W]));
                    check("wr_data_at_pulse", 64'(wr_data), 64'(we[DATA_W-1:0]));
                    check("wr_be_at_pulse", 64'(wr_be), 64'(we[DATA_W+ADDR_W +: 4]));
                end
            end
            if (rd_stb) begin
                n_rd++;
                check("rd_pulse_expected", 64'(exp_rd_q.size() != 0), 64'd1);
                if (exp_rd_q.size() != 0) begin
                    re  = exp_rd_q.pop_front();
                    lat = cyc - int'(re[RQ_W-1 -: 16]);
                    check("rd_latency_in_window", 64'(lat >= LAT_MIN && lat <= LAT_MAX), 64'd1);
                    check("rd_addr_at_pulse", 64'(rd_addr), 64'(re[ADDR_W-1:0]));
                end
            end
            if (quiet) begin
                check("quiet_busy", 64'(busy), 64'd0);
                check("quiet_wr_stb", 64'(wr_stb), 64'd0);
                check("quiet_rd_stb", 64'(rd_stb), 64'd0);
                check("quiet_err_cnt", 64'(err_cnt), 64'(m_err));
                check("quiet_wr_addr", 64'(wr_addr), 64'(m_wr_addr));
                check("quiet_wr_data", 64'(wr_data), 64'(m_wr_data));
                check("quiet_wr_be", 64'(wr_be), 64'(m_wr_be));
                check("quiet_rd_addr", 64'(rd_addr), 64'(m_rd_addr));
                check("missed_wr_pulses", 64'(exp_wr_q.size()), 64'd0);
                check("missed_rd_pulses", 64'(exp_rd_q.size()), 64'd0);
            end
        end
    end

    initial begin : watchdog
        #500000;
        n_bad++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : stimulus
        int w0;
        int r0;
        int k;

        // reset values
        wait_neg(3);
        check("reset_wr_stb", 64'(wr_stb), 64'd0);
        check("reset_rd_stb", 64'(rd_stb), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_err_cnt", 64'(err_cnt), 64'd0);
        check("reset_wr_addr", 64'(wr_addr), 64'd0);
        check("reset_wr_be", 64'(wr_be), 64'd0);
        rst_n = 1'b1;
        wait_neg(3);

        // plain write, 8-cycle strobe
        w0 = n_wr;
        access(1'b1, 1'b0, 24'h000010, 32'hDEADBEEF, 4'b0000, 8);
        k = 0;
        while (busy && k < 10) begin
            @(negedge clk);
            k++;
        end
        check("busy_fall_cycles", 64'(k), 64'd3);
        wait_neg(1);
        quiet = 1'b1;
        wait_neg(4);
        quiet = 1'b0;
        check("write_pulse_count", 64'(n_wr - w0), 64'd1);
        check("write_addr_literal", 64'(wr_addr), 64'h10);
        check("write_data_literal", 64'(wr_data), 64'hDEADBEEF);
        check("write_be_literal", 64'(wr_be), 64'hF);

        // plain read, 10-cycle strobe
        w0 = n_wr;
        r0 = n_rd;
        access(1'b0, 1'b1, 24'h000004, 32'h0, 4'hF, 10);
        settle_quiet(4);
        check("read_pulse_count", 64'(n_rd - r0), 64'd1);
        check("read_no_write", 64'(n_wr - w0), 64'd0);
        check("read_addr_literal", 64'(rd_addr), 64'h4);

        // glitch shorter than the settle window
        w0 = n_wr;
        access(1'b1, 1'b0, 24'h000040, 32'h00000001, 4'b0000, 2);
        settle_quiet(4);
        check("glitch_no_pulse", 64'(n_wr - w0), 64'd0);
        check("glitch_err_cnt", 64'(err_cnt), 64'd0);
        check("glitch_idle", 64'(busy), 64'd0);

        // write with every lane disabled
        w0 = n_wr;
        access(1'b1, 1'b0, 24'h000020, 32'hCAFEF00D, 4'hF, 8);
        settle_quiet(4);
        check("empty_no_pulse", 64'(n_wr - w0), 64'd0);
        check("empty_be_literal", 64'(wr_be), 64'h0);
        check("empty_addr_literal", 64'(wr_addr), 64'h20);
        check("empty_err_cnt", 64'(err_cnt), 64'd0);

        // simultaneous write+read strobes, enough to saturate the counter
        w0 = n_wr;
        r0 = n_rd;
        for (int i = 0; i < 300; i++) begin
            access(1'b1, 1'b1, 24'h000050, 32'h0, 4'b0000, 6);
            settle_quiet(1);
        end
        check("proto_err_saturated", 64'(err_cnt), 64'hFF);
        check("proto_no_wr", 64'(n_wr - w0), 64'd0);
        check("proto_no_rd", 64'(n_rd - r0), 64'd0);

        // reset while the FSM is settling a write, strobe held throughout
        w0 = n_wr;
        address = 24'h000030;
        data_in = 32'h12345678;
        be      = 4'b0000;
        as      = 1'b1;
        ws_n    = 1'b0;
        wait_neg(3);
        check("pre_reset_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        model_reset();
        wait_neg(1);
        check("midreset_busy", 64'(busy), 64'd0);
        check("midreset_wr_addr", 64'(wr_addr), 64'd0);
        check("midreset_wr_data", 64'(wr_data), 64'd0);
        check("midreset_rd_addr", 64'(rd_addr), 64'd0);
        check("midreset_err_cnt", 64'(err_cnt), 64'd0);
        rst_n = 1'b1;
        model_access(1'b1, 1'b0, 24'h000030, 32'h12345678, 4'b0000, 8, cyc);
        wait_neg(8);
        as   = 1'b0;
        ws_n = 1'b1;
        settle_quiet(4);
        check("after_reset_pulse_count", 64'(n_wr - w0), 64'd1);
        check("after_reset_addr_literal", 64'(wr_addr), 64'h30);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
